axi_write_master: RTL and testbench

Single-ID AXI4 write master that drains one AXI4-Stream of results and writes exactly ctrl_length beats to memory starting at ctrl_offset, in full bursts of C_BURST_LEN plus an optional final partial burst. It sits downstream of the read master and compute stage in the kernel datapath and closes the memory-to-memory loop. Completion is reported only after every write response has returned.

---
 rtl/axi_write_master.sv | 143 ++++++++++++++
 tb/tb_axi_write_master.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_master.sv
// Single-ID AXI4 write master: drains an AXI4-Stream into memory as full bursts
// plus an optional partial tail, and signals completion once every B has returned.
module axi_write_master #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_DATA_WIDTH      = 32,
  parameter int C_LENGTH_WIDTH    = 32,
  parameter int C_BURST_LEN       = 256,
  parameter int C_LOG_BURST_LEN   = 8,
  parameter int C_MAX_OUTSTANDING = 3
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      ctrl_start,
  output logic                      ctrl_done,
  output logic                      ctrl_error,
  input  logic [C_ADDR_WIDTH-1:0]   ctrl_offset,
  input  logic [C_LENGTH_WIDTH-1:0] ctrl_length,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic [C_DATA_WIDTH-1:0]   s_tdata,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [C_ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]                awlen,
  output logic [2:0]                awsize,
  output logic                      wvalid,
  input  logic                      wready,
  output logic [C_DATA_WIDTH-1:0]   wdata,
  output logic [C_DATA_WIDTH/8-1:0] wstrb,
  output logic                      wlast,
  input  logic                      bvalid,
  output logic                      bready,
  input  logic [1:0]                bresp
);
  localparam int BCW = C_LENGTH_WIDTH - C_LOG_BURST_LEN + 1;
  localparam int FLW = C_LOG_BURST_LEN + 1;
  localparam int OW  = $clog2(C_MAX_OUTSTANDING + 1);
  localparam logic [C_ADDR_WIDTH-1:0] BURST_BYTES = C_ADDR_WIDTH'(C_BURST_LEN * (C_DATA_WIDTH / 8));
  localparam logic [FLW-1:0]          FULL_LEN    = FLW'(C_BURST_LEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [BCW-1:0]            total_bursts, aw_issued, w_bursts, b_count, start_bursts;
  logic [FLW-1:0]            final_len, beat_cnt, w_len, start_final;
  logic [OW-1:0]             outstanding;
  logic [C_LENGTH_WIDTH:0]   len_round;
  logic [C_LENGTH_WIDTH-1:0] len_rem;
  logic                      start_ok, aw_hs, w_hs, b_hs, w_ok, last_aw;

  // Burst count is a ceiling divide; one extra bit keeps the max length from wrapping.
  assign start_ok     = (state == IDLE) && ctrl_start;
  assign len_round    = {1'b0, ctrl_length} + (C_LENGTH_WIDTH+1)'(C_BURST_LEN - 1);
  assign start_bursts = BCW'(len_round >> C_LOG_BURST_LEN);
  assign len_rem      = ctrl_length & C_LENGTH_WIDTH'(C_BURST_LEN - 1);
  assign start_final  = (len_rem == '0) ? FULL_LEN : len_rem[FLW-1:0];

  // W data may only flow for bursts whose address has already been accepted.
  assign w_ok     = (state == RUN) && (w_bursts < aw_issued);
  assign wvalid   = w_ok & s_tvalid;
  assign s_tready = w_ok & wready;
  assign wdata    = s_tdata;
  assign wstrb    = '1;
  assign w_len    = (w_bursts == total_bursts - 1'b1) ? final_len : FULL_LEN;
  assign wlast    = w_ok && (beat_cnt == w_len - 1'b1);

  assign aw_hs     = awvalid & awready;
  assign w_hs      = wvalid & wready;
  assign b_hs      = bvalid & (state == RUN);
  assign bready    = 1'b1;
  assign awsize    = 3'($clog2(C_DATA_WIDTH / 8));
  assign ctrl_done = (state == DONE);
  assign last_aw   = (aw_issued == total_bursts - 1'b1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ctrl_start) state_nxt = (ctrl_length == '0) ? DONE : RUN;
      RUN:     if (b_hs && (b_count + 1'b1 == total_bursts)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset)
    if (areset) state <= IDLE;
    else        state <= state_nxt;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      total_bursts <= '0;
      final_len    <= '0;
      aw_issued    <= '0;
      w_bursts     <= '0;
      b_count      <= '0;
      beat_cnt     <= '0;
      outstanding  <= '0;
      awvalid      <= 1'b0;
      awaddr       <= '0;
      awlen        <= '0;
      ctrl_error   <= 1'b0;
    end else if (start_ok) begin
      total_bursts <= start_bursts;
      final_len    <= start_final;
      awaddr       <= ctrl_offset;
      aw_issued    <= '0;
      w_bursts     <= '0;
      b_count      <= '0;
      beat_cnt     <= '0;
      outstanding  <= '0;
      awvalid      <= 1'b0;
      ctrl_error   <= 1'b0;
    end else if (state == RUN) begin
      // awvalid drops for a cycle after each handshake before the next burst.
      if (aw_hs) begin
        awvalid   <= 1'b0;
        aw_issued <= aw_issued + 1'b1;
        awaddr    <= awaddr + BURST_BYTES;
      end else if (!awvalid && (aw_issued < total_bursts) &&
                   (outstanding < OW'(C_MAX_OUTSTANDING))) begin
        awvalid <= 1'b1;
        awlen   <= last_aw ? 8'(final_len - 1'b1) : 8'(C_BURST_LEN - 1);
      end
      if (w_hs) begin
        if (wlast) begin
          beat_cnt <= '0;
          w_bursts <= w_bursts + 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
      if (b_hs) begin
        b_count <= b_count + 1'b1;
        if (bresp != 2'b00) ctrl_error <= 1'b1;
      end
      case ({aw_hs, b_hs})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_write_master.sv
// Scoreboard bench for axi_write_master: expected AW/W streams come from a burst
// model of each run; monitors pop and compare at every handshake.
module tb_axi_write_master;
  localparam int AW = 64, DW = 32, LW = 32, BL = 256, LBL = 8, MO = 3;

  logic          aclk = 1'b0, areset = 1'b1;
  logic          ctrl_start = 1'b0, ctrl_done, ctrl_error;
  logic [AW-1:0] ctrl_offset = '0;
  logic [LW-1:0] ctrl_length = '0;
  logic          s_tvalid = 1'b0, s_tready;
  logic [DW-1:0] s_tdata = '0;
  logic          awvalid, awready = 1'b0;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic          wvalid, wready = 1'b0, wlast;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          bvalid = 1'b0, bready;
  logic [1:0]    bresp = 2'b00;

  axi_write_master #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_LENGTH_WIDTH(LW),
    .C_BURST_LEN(BL), .C_LOG_BURST_LEN(LBL), .C_MAX_OUTSTANDING(MO)) dut (
    .aclk(aclk), .areset(areset), .ctrl_start(ctrl_start), .ctrl_done(ctrl_done),
    .ctrl_error(ctrl_error), .ctrl_offset(ctrl_offset), .ctrl_length(ctrl_length),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp));

  always #5 aclk = ~aclk;

  typedef struct { logic [63:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [31:0] data; logic last; } w_t;
  aw_t aw_exp[$];
  w_t  w_exp[$];
  logic [31:0] src_q[$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0, rnd_mode = 0, err_burst = -1, b_idx = 0, b_tokens = 0;
  int aw_cnt = 0, w_cnt = 0, outst = 0, max_outst = 0, consumed = 0;
  int last_b_cyc = 0, done_cyc = 0, done_cnt = 0, start_cyc = 0;
  bit hold_b = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: samples on the falling edge, i.e. the values the next rising edge will see.
  aw_t e_aw; w_t e_w;
  logic p_awv, p_awhs, p_wv, p_whs;
  logic [63:0] p_awaddr; logic [7:0] p_awlen; logic [31:0] p_wdata;
  always @(negedge aclk) begin
    cyc++;
    if (areset) begin
      p_awv = 0; p_wv = 0; outst = 0;
    end else begin
      if (p_awv && !p_awhs) begin
        chk("aw_hold_valid", 64'(awvalid), 64'd1);
        chk("aw_hold_addr", awaddr, p_awaddr);
        chk("aw_hold_len", 64'(awlen), 64'(p_awlen));
      end
      if (p_wv && !p_whs) begin
        chk("w_hold_valid", 64'(wvalid), 64'd1);
        chk("w_hold_data", 64'(wdata), 64'(p_wdata));
      end
      if (awvalid && awready) begin
        aw_cnt++;
        if (aw_exp.size() == 0) chk("aw_unexpected", 64'd1, 64'd0);
        else begin
          e_aw = aw_exp.pop_front();
          chk("awaddr", awaddr, e_aw.addr);
          chk("awlen", 64'(awlen), 64'(e_aw.len));
        end
      end
      if (wvalid && wready) begin
        w_cnt++;
        if (w_exp.size() == 0) chk("w_unexpected", 64'd1, 64'd0);
        else begin
          e_w = w_exp.pop_front();
          chk("wdata", 64'(wdata), 64'(e_w.data));
          chk("wlast", 64'(wlast), 64'(e_w.last));
        end
        if (wlast) b_tokens++;
      end
      if (bvalid && bready) last_b_cyc = cyc;
      outst += int'(awvalid && awready) - int'(bvalid && bready);
      if (outst > max_outst) max_outst = outst;
      if (ctrl_done) begin done_cnt++; done_cyc = cyc; end
      p_awv = awvalid; p_awhs = awvalid && awready; p_awaddr = awaddr; p_awlen = awlen;
      p_wv = wvalid; p_whs = wvalid && wready; p_wdata = wdata;
    end
  end

  // Stream source: holds tvalid/tdata until accepted, then advances through src_q.
  bit shs;
  initial forever begin
    @(negedge aclk); shs = s_tvalid && s_tready;
    @(posedge aclk); #1;
    if (shs && src_q.size() > 0) begin void'(src_q.pop_front()); consumed++; end
    if (src_q.size() > 0) begin
      if (!(s_tvalid && !shs)) s_tvalid = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_tdata = src_q[0];
    end else s_tvalid = 1'b0;
  end

  // Slave: random ready, one B per completed W burst.
  always @(posedge aclk) begin
    #1;
    awready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    wready  = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    bvalid  = 1'b0;
    bresp   = 2'b00;
    if (areset) b_tokens = 0;
    else if (!hold_b && b_tokens > 0 && (!rnd_mode || $urandom_range(0, 1) == 1)) begin
      bvalid = 1'b1;
      bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
      b_tokens--; b_idx++;
    end
  end

  // Reference model: bursts of BL beats at BL*4-byte strides, short tail burst.
  task automatic load(input int len, input logic [63:0] off);
    int nb; logic [31:0] d;
    nb = (len + BL - 1) / BL;
    for (int k = 0; k < nb; k++) begin
      aw_t a;
      a.addr = off + 64'(k) * 64'(BL * DW / 8);
      a.len  = (k == nb - 1) ? 8'(len - k * BL - 1) : 8'(BL - 1);
      aw_exp.push_back(a);
    end
    src_q.delete();
    for (int i = 0; i < len + 5; i++) begin
      w_t w;
      d = $urandom;
      src_q.push_back(d);
      w.data = d; w.last = ((i % BL) == BL - 1) || (i == len - 1);
      if (i < len) w_exp.push_back(w);
    end
    consumed = 0; b_idx = 0;
  endtask

  task automatic start(input int len, input logic [63:0] off);
    @(posedge aclk); #2;
    ctrl_length = LW'(len); ctrl_offset = off; ctrl_start = 1'b1;
    start_cyc = cyc + 1;
    @(posedge aclk); #2;
    ctrl_start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int bound);
    int t = 0;
    while (done_cnt == d0 && t < bound) begin @(posedge aclk); t++; end
    if (done_cnt == d0) chk("done_timeout", 64'd0, 64'd1);
    #3;
  endtask

  task automatic run_check(input string nm, input int len, input logic [63:0] off, input logic exp_err);
    int d0 = done_cnt;
    load(len, off);
    start(len, off);
    wait_done(d0, 20000);
    chk({nm, "_done_after_b"}, 64'(done_cyc - last_b_cyc), 64'd1);
    chk({nm, "_error"}, 64'(ctrl_error), 64'(exp_err));
    repeat (10) @(posedge aclk);
    #3;
    chk({nm, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    chk({nm, "_aw_left"}, 64'(aw_exp.size()), 64'd0);
    chk({nm, "_w_left"}, 64'(w_exp.size()), 64'd0);
    chk({nm, "_consumed"}, 64'(consumed), 64'(len));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, w0, d0;
    repeat (3) @(posedge aclk);
    #3;
    chk("rst_awvalid", 64'(awvalid), 64'd0);
    chk("rst_wvalid", 64'(wvalid), 64'd0);
    chk("rst_wlast", 64'(wlast), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_done", 64'(ctrl_done), 64'd0);
    chk("rst_error", 64'(ctrl_error), 64'd0);
    chk("rst_awaddr", awaddr, 64'd0);
    chk("rst_awlen", 64'(awlen), 64'd0);
    chk("awsize", 64'(awsize), 64'd2);
    chk("wstrb", 64'(wstrb), 64'hf);
    chk("bready", 64'(bready), 64'd1);
    @(posedge aclk); #2; areset = 1'b0;

    run_check("len512", 512, 64'h1000_0000, 1'b0);
    run_check("len300", 300, 64'h0000_2000, 1'b0);

    // Zero length: no traffic, done one cycle after start.
    a0 = aw_cnt; w0 = w_cnt; d0 = done_cnt;
    start(0, 64'h4000);
    wait_done(d0, 20);
    chk("len0_done_cycle", 64'(done_cyc - start_cyc), 64'd1);
    repeat (5) @(posedge aclk);
    chk("len0_no_aw", 64'(aw_cnt - a0), 64'd0);
    chk("len0_no_w", 64'(w_cnt - w0), 64'd0);

    // B withheld: at most three bursts may be in flight.
    hold_b = 1; max_outst = 0; a0 = aw_cnt; d0 = done_cnt;
    load(2048, 64'h8000_0000);
    start(2048, 64'h8000_0000);
    repeat (1000) @(posedge aclk);
    #3;
    chk("hold_aw_count", 64'(aw_cnt - a0), 64'd3);
    chk("hold_awvalid_low", 64'(awvalid), 64'd0);
    hold_b = 0;
    wait_done(d0, 20000);
    chk("hold_max_outst", 64'(max_outst), 64'd3);
    chk("hold_aw_left", 64'(aw_exp.size()), 64'd0);
    chk("hold_w_left", 64'(w_exp.size()), 64'd0);
    chk("hold_done_after_b", 64'(done_cyc - last_b_cyc), 64'd1);

    // Random backpressure plus a stray start mid-run that must be ignored.
    rnd_mode = 1; d0 = done_cnt;
    load(1000, 64'h0123_4000);
    start(1000, 64'h0123_4000);
    repeat (60) @(posedge aclk);
    start(7, 64'hdead_0000);
    wait_done(d0, 20000);
    chk("rnd_aw_left", 64'(aw_exp.size()), 64'd0);
    chk("rnd_w_left", 64'(w_exp.size()), 64'd0);
    chk("rnd_done_pulses", 64'(done_cnt - d0), 64'd1);
    repeat (10) @(posedge aclk);
    chk("rnd_consumed", 64'(consumed), 64'd1000);
    rnd_mode = 0;

    // Error response is sticky through done and cleared by the next start.
    err_burst = 1;
    run_check("err", 512, 64'h0010_0000, 1'b1);
    chk("err_sticky", 64'(ctrl_error), 64'd1);
    err_burst = -1; d0 = done_cnt;
    load(256, 64'h0020_0000);
    start(256, 64'h0020_0000);
    chk("err_cleared_on_start", 64'(ctrl_error), 64'd0);
    wait_done(d0, 20000);
    chk("err_clean_run", 64'(ctrl_error), 64'd0);

    // Reset mid-burst abandons the transfer.
    err_burst = 0;
    load(512, 64'h0030_0000);
    start(512, 64'h0030_0000);
    repeat (100) @(posedge aclk);
    #3; areset = 1'b1; #1;
    chk("mid_rst_awvalid", 64'(awvalid), 64'd0);
    chk("mid_rst_wvalid", 64'(wvalid), 64'd0);
    chk("mid_rst_s_tready", 64'(s_tready), 64'd0);
    chk("mid_rst_wlast", 64'(wlast), 64'd0);
    chk("mid_rst_awaddr", awaddr, 64'd0);
    chk("mid_rst_error", 64'(ctrl_error), 64'd0);
    aw_exp.delete(); w_exp.delete();
    repeat (2) @(posedge aclk);
    #2; areset = 1'b0; err_burst = -1;
    a0 = aw_cnt; w0 = w_cnt;
    repeat (30) @(posedge aclk);
    chk("post_rst_no_aw", 64'(aw_cnt - a0), 64'd0);
    chk("post_rst_no_w", 64'(w_cnt - w0), 64'd0);
    run_check("recover", 40, 64'h0040_0000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
